fetch_sequencer: RTL

//  Sequences instruction fetch: owns the program counter, drives the instruction

---
 rtl/fetch_sequencer.sv | 108 ++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, reads imem combinationally and
// registers each word into a valid/ready stage toward decode.
module fetch_sequencer #(
  parameter int                  PC_WIDTH    = 8,
  parameter int                  INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
  parameter logic [5:0]          HALT_OPCODE = 6'b111111
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   redirect_valid,
  input  logic [PC_WIDTH-1:0]    redirect_pc,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INSTR_WIDTH-1:0] out_instr,
  output logic [PC_WIDTH-1:0]    out_pc,
  output logic [PC_WIDTH-1:0]    out_pc_next,
  output logic                   halted
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HALT
  } state_t;

  localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

  state_t                 state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic                   valid_q, valid_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [PC_WIDTH-1:0]    opc_q, opc_d;
  logic                   halted_q, halted_d;
  logic                   fire;
  logic                   is_halt;

  assign fire = (state_q == S_RUN)
              && (!valid_q || out_ready)
              && !redirect_valid;
  assign is_halt = (imem_data[31:26] == HALT_OPCODE);

  // State and output-stage registers; reset drops any in-flight word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      valid_q  <= 1'b0;
      instr_q  <= '0;
      opc_q    <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      instr_q  <= instr_d;
      opc_q    <= opc_d;
      halted_q <= halted_d;
    end
  end

  // Next state: redirect beats fetch, stall and accept outside IDLE.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    valid_d  = valid_q;
    instr_d  = instr_q;
    opc_d    = opc_q;
    halted_d = halted_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_RUN;
      end
      S_RUN, S_HALT: begin
        if (redirect_valid) begin
          pc_d     = redirect_pc;
          valid_d  = 1'b0;
          halted_d = 1'b0;
          state_d  = S_RUN;
        end else if (fire) begin
          instr_d = imem_data;
          opc_d   = pc_q;
          valid_d = 1'b1;
          if (is_halt) begin
            state_d  = S_HALT;
            halted_d = 1'b1;
          end else begin
            pc_d = pc_q + PC_ONE;
          end
        end else if (state_q == S_HALT && out_ready) begin
          valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign imem_addr   = pc_q;
  assign out_valid   = valid_q;
  assign out_instr   = instr_q;
  assign out_pc      = opc_q;
  assign out_pc_next = opc_q + PC_ONE;
  assign halted      = halted_q;

endmodule
